// File: rtl/serial_ripple_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
// State encoding and counter sizing helper.
package serial_ripple_subtractor_pkg;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    function automatic int cnt_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/serial_ripple_subtractor_fs.sv
// One-bit full subtractor cell, twin of the full-adder cell.
// d = x - y - bin (mod 2), bout = borrow out.
module fullsubtractor_1 (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial ripple-borrow subtractor, LSB first.
// One cell reused for chainnumber cycles per operation.
module serial_ripple_subtractor
    import serial_ripple_subtractor_pkg::*;
#(
    parameter int chainnumber = 8
) (
    input  logic                   clk1,
    input  logic                   rst,
    input  logic                   start,
    input  logic [chainnumber-1:0] X,
    input  logic [chainnumber-1:0] Y,
    input  logic                   Borrowin,
    output logic                   ready,
    output logic                   busy,
    output logic                   done,
    output logic [chainnumber-1:0] Diff,
    output logic                   Borrowout
);

    localparam int CW = cnt_w(chainnumber);
    localparam logic [CW-1:0] LAST = CW'(chainnumber - 1);

    logic [1:0]             state;
    logic [CW-1:0]          cnt;
    logic [chainnumber-1:0] xr;
    logic [chainnumber-1:0] yr;
    logic [chainnumber-2:0] res;
    logic [chainnumber-1:0] res_next;
    logic                   b;
    logic                   d;
    logic                   bout;
    logic                   accept;

    fullsubtractor_1 u_cell (
        .x    (xr[0]),
        .y    (yr[0]),
        .bin  (b),
        .d    (d),
        .bout (bout)
    );

    // New bit enters at the top; after the last bit the vector is the full result.
    assign res_next = {d, res};

    // Handshake flags decode straight from the state register.
    assign ready  = (state == S_IDLE) || (state == S_DONE);
    assign busy   = (state == S_RUN);
    assign done   = (state == S_DONE);
    assign accept = start && ready;

    // FSM, operand shifters, borrow flop and result registers.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            xr        <= '0;
            yr        <= '0;
            res       <= '0;
            b         <= 1'b0;
            Diff      <= '0;
            Borrowout <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    res <= res_next[chainnumber-1:1];
                    xr  <= xr >> 1;
                    yr  <= yr >> 1;
                    b   <= bout;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        Diff      <= res_next;
                        Borrowout <= bout;
                        state     <= S_DONE;
                    end
                end
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        xr    <= X;
                        yr    <= Y;
                        b     <= Borrowin;
                        res   <= '0;
                        cnt   <= '0;
                        state <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Bench for the bit-serial subtractor.
// Reference results from plain wide unsigned arithmetic.
module tb_serial_ripple_subtractor;

    localparam int W = 8;

    logic         clk1;
    logic         rst;
    logic         start;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic         Borrowin;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] Diff;
    logic         Borrowout;

    int tests;
    int fails;

    logic [W-1:0] m_diff;
    logic         m_bo;

    serial_ripple_subtractor #(.chainnumber(W)) dut (
        .clk1      (clk1),
        .rst       (rst),
        .start     (start),
        .X         (X),
        .Y         (Y),
        .Borrowin  (Borrowin),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .Diff      (Diff),
        .Borrowout (Borrowout)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    function automatic logic [W:0] ref_sub(input logic [W-1:0] a,
                                           input logic [W-1:0] bb,
                                           input logic bin);
        int unsigned av;
        int unsigned bv;
        int unsigned tot;
        av  = a;
        bv  = int'(bb) + int'(bin);
        tot = av + (1 << W) - bv;
        return {(av < bv), tot[W-1:0]};
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] bb,
                          input logic bin, input string nm);
        logic [W:0] r;
        int n;
        int g;
        logic holdbad;
        r = ref_sub(a, bb, bin);
        g = 0;
        while (!ready && g < 20) begin
            @(posedge clk1); #1;
            g++;
        end
        tests++;
        if (ready !== 1'b1) begin
            fails++;
            $display("FAIL %s ready-wait: ready=%b required 1", nm, ready);
        end
        start = 1'b1; X = a; Y = bb; Borrowin = bin;
        @(posedge clk1); #1;
        start = 1'b0;
        X = W'($urandom); Y = W'($urandom); Borrowin = 1'($urandom);
        holdbad = 1'b0;
        n = 0;
        while (n < 20) begin
            if (Diff !== m_diff || Borrowout !== m_bo || ready !== 1'b0 || busy !== 1'b1)
                holdbad = 1'b1;
            @(posedge clk1); #1;
            n++;
            if (done === 1'b1) break;
        end
        tests++;
        if (holdbad) begin
            fails++;
            $display("FAIL %s run-phase: outputs/flags changed during RUN (last Diff=%0d)", nm, Diff);
        end
        tests++;
        if (done !== 1'b1 || n != W) begin
            fails++;
            $display("FAIL %s latency: done after %0d edges required %0d", nm, n, W);
        end
        tests++;
        if (Diff !== r[W-1:0] || Borrowout !== r[W]) begin
            fails++;
            $display("FAIL %s result: Diff=%0d Bo=%b required Diff=%0d Bo=%b",
                     nm, Diff, Borrowout, r[W-1:0], r[W]);
        end
        m_diff = r[W-1:0];
        m_bo   = r[W];
        @(posedge clk1); #1;
        tests++;
        if (done !== 1'b0 || ready !== 1'b1 || busy !== 1'b0 || Diff !== m_diff) begin
            fails++;
            $display("FAIL %s after-done: done=%b ready=%b busy=%b Diff=%0d required 0 1 0 %0d",
                     nm, done, ready, busy, Diff, m_diff);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; X = '0; Y = '0; Borrowin = 1'b0;
        repeat (2) @(posedge clk1);
        #1;
        rst = 1'b0;
        m_diff = '0;
        m_bo   = 1'b0;
        tests++;
        if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
            Diff !== '0 || Borrowout !== 1'b0) begin
            fails++;
            $display("FAIL reset: ready=%b busy=%b done=%b Diff=%0d Bo=%b required 1 0 0 0 0",
                     ready, busy, done, Diff, Borrowout);
        end
    endtask

    task automatic test_directed;
        run_op(8'd100, 8'd58, 1'b0, "100-58");
        run_op(8'd5, 8'd7, 1'b0, "5-7");
        run_op(8'd0, 8'd0, 1'b1, "0-0-1");
        run_op(8'd255, 8'd0, 1'b0, "255-0");
        run_op(8'd128, 8'd127, 1'b1, "128-127-1");
    endtask

    task automatic test_random;
        for (int i = 0; i < 20; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), "random");
    endtask

    task automatic test_back_to_back;
        logic [W:0] r1;
        logic [W:0] r2;
        int n;
        r1 = ref_sub(8'd200, 8'd50, 1'b0);
        r2 = ref_sub(8'd9, 8'd3, 1'b0);
        start = 1'b1; X = 8'd200; Y = 8'd50; Borrowin = 1'b0;
        @(posedge clk1); #1;
        X = 8'd9; Y = 8'd3;
        n = 0;
        while (n < 20) begin
            @(posedge clk1); #1;
            n++;
            if (done === 1'b1) break;
        end
        tests++;
        if (n != W || Diff !== r1[W-1:0] || Borrowout !== r1[W]) begin
            fails++;
            $display("FAIL b2b-first: edges=%0d Diff=%0d Bo=%b required %0d %0d %b",
                     n, Diff, Borrowout, W, r1[W-1:0], r1[W]);
        end
        @(posedge clk1); #1;
        start = 1'b0;
        tests++;
        if (done !== 1'b0 || busy !== 1'b1 || ready !== 1'b0) begin
            fails++;
            $display("FAIL b2b-accept: done=%b busy=%b ready=%b required 0 1 0",
                     done, busy, ready);
        end
        n = 0;
        while (n < 20) begin
            @(posedge clk1); #1;
            n++;
            if (done === 1'b1) break;
            if (n == 3) begin
                start = 1'b1; X = 8'd77; Y = 8'd1;
            end
            if (n == 4) start = 1'b0;
        end
        tests++;
        if (n != W || Diff !== r2[W-1:0] || Borrowout !== r2[W]) begin
            fails++;
            $display("FAIL b2b-second: edges=%0d Diff=%0d Bo=%b required %0d %0d %b",
                     n, Diff, Borrowout, W, r2[W-1:0], r2[W]);
        end
        m_diff = r2[W-1:0];
        m_bo   = r2[W];
        @(posedge clk1); #1;
        tests++;
        if (done !== 1'b0 || ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b-idle: done=%b ready=%b busy=%b required 0 1 0",
                     done, ready, busy);
        end
    endtask

    task automatic test_reset_midop;
        int seen;
        start = 1'b1; X = 8'd201; Y = 8'd17; Borrowin = 1'b1;
        @(posedge clk1); #1;
        start = 1'b0;
        repeat (4) @(posedge clk1);
        #1;
        rst = 1'b1;
        @(posedge clk1); #1;
        rst = 1'b0;
        m_diff = '0;
        m_bo   = 1'b0;
        tests++;
        if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
            Diff !== '0 || Borrowout !== 1'b0) begin
            fails++;
            $display("FAIL midop-reset: ready=%b busy=%b done=%b Diff=%0d Bo=%b required 1 0 0 0 0",
                     ready, busy, done, Diff, Borrowout);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk1); #1;
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL midop-quiet: %0d cycles with done/busy set, required 0", seen);
        end
        run_op(8'd60, 8'd61, 1'b0, "post-reset");
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
